com_tx_arbiter: RTL and testbench
=================================

# com_tx_arbiter

Shares the single serial transmit channel (com_data_out / com_write_enable / write_ready) between two byte sources: the debug console controller (port D) and the CPU memory-mapped serial output (port C). Selects a winner by round-robin and honours a debug lock so multi-byte debug bursts (e.g. 8-digit hex register dumps) are never interleaved with CPU bytes. Generates the write-enable strobe and the inter-byte recovery gap. Sits between both requesters and the UART.

## Interface
- WE_CYCLES, 2: cycles com_write_enable is held high per byte; legal range 1..255.
- GAP_CYCLES, 4: idle cycles with com_write_enable low after each strobe; legal range 1..255.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- dbg_req  in  1  debug console requests one byte
- dbg_data  in  8  debug byte; stable while dbg_req=1
- dbg_lock  in  1  debug holds channel across bytes
- dbg_ack  out  1  one-cycle pulse: debug byte accepted
- cpu_req  in  1  CPU requests one byte
- cpu_data  in  8  CPU byte; stable while cpu_req=1
- cpu_ack  out  1  one-cycle pulse: CPU byte accepted
- write_ready  in  1  UART can accept a byte
- com_data_out  out  8  byte to UART
- com_write_enable  out  1  UART write strobe
- busy  out  1  high in STROBE or GAP
- grant_id  out  1  source of current/last byte: 0=debug, 1=CPU

## Operation
- FSM states: IDLE, STROBE, GAP. 8-bit down-counter cnt; last_grant register.
- IDLE: if write_ready=1 and eligible request exists -> grant, go STROBE, cnt<=WE_CYCLES-1. Else stay.
- Eligibility: if dbg_lock=1 and last_grant=0, only debug is eligible (CPU waits, even if debug not requesting). Otherwise both are eligible.
- Arbitration among eligible requesters: single request wins; both -> the one not equal to last_grant wins.
- On grant: com_data_out<=winner data, com_write_enable<=1, winner ack<=1, grant_id<=winner, last_grant<=winner.
- STROBE: ack forced 0; com_write_enable=1; cnt=0 -> GAP, cnt<=GAP_CYCLES-1, com_write_enable<=0; else cnt<=cnt-1.
- GAP: com_write_enable=0; cnt=0 -> IDLE; else decrement.
- com_data_out holds the last byte until the next grant.
- write_ready changes during STROBE/GAP are ignored; write_ready sampled only in IDLE.
- Requester drops req (or presents next byte) in the cycle after seeing ack; req sampled only in IDLE, so no duplicate issue.
- Dropping req before ack withdraws the request; no byte sent.

## Timing
- Reset (async): state IDLE, cnt=0, com_data_out=0x00, com_write_enable=0, dbg_ack=0, cpu_ack=0, busy=0, grant_id=0, last_grant=1 (debug wins first tie).
- Grant latency: request and write_ready seen at edge N -> com_write_enable, ack, data valid after edge N.
- com_write_enable high exactly WE_CYCLES cycles, then low GAP_CYCLES cycles, then at least 1 cycle of IDLE.
- Minimum byte period: WE_CYCLES+GAP_CYCLES+1 cycles (7 at defaults).
- busy = (state != IDLE), registered with state.
- Reset mid-byte: com_write_enable and acks drop immediately; byte in flight is abandoned; no ack re-issue after release.
- dbg_lock changes take effect at the next IDLE evaluation only.

## Test plan
- Reset: rst pulse mid-STROBE -> com_write_enable=0 same cycle; all outputs at reset values; first tie afterwards grants debug.
- Single debug byte: dbg_req=1, dbg_data=0x41, write_ready=1 -> dbg_ack 1 cycle, com_data_out=0x41, com_write_enable high 2 cycles, low 4, busy 6 cycles, grant_id=0.
- Tie round-robin: both req held, dbg 0x30, cpu 0x55 -> sequence 0x30, 0x55, 0x30, 0x55, byte starts 7 cycles apart.
- Lock: dbg_lock=1 after a debug grant, cpu_req=1 continuous, debug sends 8 bytes "0000ABCD" with gaps -> all 8 debug bytes contiguous, no CPU byte; lock released -> next byte CPU.
- Backpressure: write_ready=0 with dbg_req=1 for 20 cycles -> no ack, no strobe; write_ready=1 -> grant next cycle; write_ready dropping during GAP does not shorten/extend the sequence.
- Parameters WE_CYCLES=1, GAP_CYCLES=1 -> strobe 1 cycle, back-to-back bytes every 3 cycles; withdrawn request (req dropped while write_ready=0) -> no byte sent.

Source files
------------

// File: rtl/com_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit channel between the debug console and the CPU.
// Emits a WE_CYCLES-long write strobe per byte followed by a GAP_CYCLES recovery gap.
module com_tx_arbiter #(
    parameter int unsigned WE_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dbg_req,
    input  logic [7:0] dbg_data,
    input  logic       dbg_lock,
    output logic       dbg_ack,
    input  logic       cpu_req,
    input  logic [7:0] cpu_data,
    output logic       cpu_ack,
    input  logic       write_ready,
    output logic [7:0] com_data_out,
    output logic       com_write_enable,
    output logic       busy,
    output logic       grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } state_t;

    localparam logic [7:0] WE_LOAD  = 8'(WE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       last_grant;

    logic cpu_eligible;
    logic dbg_cand;
    logic cpu_cand;
    logic grant_any;
    logic winner;

    // A locked debug burst keeps the CPU out even between debug bytes.
    always_comb begin
        // NOTE: every combinational output gets a value on every path so no latch is inferred.
        cpu_eligible = !(dbg_lock && !last_grant);
        dbg_cand     = dbg_req;
        cpu_cand     = cpu_req && cpu_eligible;
        grant_any    = write_ready && (dbg_cand || cpu_cand);
        winner       = (dbg_cand && cpu_cand) ? ~last_grant : cpu_cand;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 8'd0;
            last_grant       <= 1'b1;
            com_data_out     <= 8'h00;
            com_write_enable <= 1'b0;
            dbg_ack          <= 1'b0;
            cpu_ack          <= 1'b0;
            busy             <= 1'b0;
            grant_id         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state            <= STROBE;
                        cnt              <= WE_LOAD;
                        com_data_out     <= winner ? cpu_data : dbg_data;
                        com_write_enable <= 1'b1;
                        dbg_ack          <= ~winner;
                        cpu_ack          <= winner;
                        grant_id         <= winner;
                        last_grant       <= winner;
                        busy             <= 1'b1;
                    end
                end
                STROBE: begin
                    dbg_ack <= 1'b0;
                    cpu_ack <= 1'b0;
                    if (cnt == 8'd0) begin
                        state            <= GAP;
                        cnt              <= GAP_LOAD;
                        com_write_enable <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state            <= IDLE;
                    com_write_enable <= 1'b0;
                    dbg_ack          <= 1'b0;
                    cpu_ack          <= 1'b0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_com_tx_arbiter.sv
// Bench for com_tx_arbiter: default and minimum-timing instances checked every cycle
// against a byte-start-time model under directed and random stimulus.
module tb_com_tx_arbiter;

    localparam int WE0 = 2, GAP0 = 4, WE1 = 1, GAP1 = 1;

    logic clk = 1'b0;
    logic rst;

    logic       dbg_req[2], dbg_lock[2], cpu_req[2], write_ready[2];
    logic [7:0] dbg_data[2], cpu_data[2];
    logic       dbg_ack[2], cpu_ack[2], com_write_enable[2], busy[2], grant_id[2];
    logic [7:0] com_data_out[2];

    always #5 clk = ~clk;

    com_tx_arbiter #(.WE_CYCLES(WE0), .GAP_CYCLES(GAP0)) u_dut0 (
        .clk(clk), .rst(rst),
        .dbg_req(dbg_req[0]), .dbg_data(dbg_data[0]), .dbg_lock(dbg_lock[0]), .dbg_ack(dbg_ack[0]),
        .cpu_req(cpu_req[0]), .cpu_data(cpu_data[0]), .cpu_ack(cpu_ack[0]),
        .write_ready(write_ready[0]), .com_data_out(com_data_out[0]),
        .com_write_enable(com_write_enable[0]), .busy(busy[0]), .grant_id(grant_id[0])
    );

    com_tx_arbiter #(.WE_CYCLES(WE1), .GAP_CYCLES(GAP1)) u_dut1 (
        .clk(clk), .rst(rst),
        .dbg_req(dbg_req[1]), .dbg_data(dbg_data[1]), .dbg_lock(dbg_lock[1]), .dbg_ack(dbg_ack[1]),
        .cpu_req(cpu_req[1]), .cpu_data(cpu_data[1]), .cpu_ack(cpu_ack[1]),
        .write_ready(write_ready[1]), .com_data_out(com_data_out[1]),
        .com_write_enable(com_write_enable[1]), .busy(busy[1]), .grant_id(grant_id[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: a byte occupies the channel for WE+GAP cycles from its grant edge, plus one idle edge.
    bit         m_active[2];
    int         m_start[2];
    bit         m_last[2];
    logic [7:0] m_data[2];
    bit         m_gid[2];
    int         edge_n = 0;

    bit agent_on = 0;
    int wr_prob  = 6;
    int lock_mode = 0;
    bit cpu_hold = 0;

    function automatic int we_of(int u);
        return (u == 0) ? WE0 : WE1;
    endfunction

    function automatic int gap_of(int u);
        return (u == 0) ? GAP0 : GAP1;
    endfunction

    function automatic bit exp_ack(int u, bit src);
        return m_active[u] && (m_start[u] == edge_n) && (m_gid[u] == src);
    endfunction

    task automatic check_unit(int u);
        int off;
        bit e_we, e_busy;
        logic [7:0] e_data;
        bit e_gid;
        e_we = 0; e_busy = 0; e_data = 8'h00; e_gid = 0;
        if (m_active[u]) begin
            off    = edge_n - m_start[u];
            e_we   = off < we_of(u);
            e_busy = off < (we_of(u) + gap_of(u));
            e_data = m_data[u];
            e_gid  = m_gid[u];
        end
        check($sformatf("u%0d we", u),    32'(com_write_enable[u]), 32'(e_we));
        check($sformatf("u%0d busy", u),  32'(busy[u]),             32'(e_busy));
        check($sformatf("u%0d dack", u),  32'(dbg_ack[u]),          32'(exp_ack(u, 1'b0)));
        check($sformatf("u%0d cack", u),  32'(cpu_ack[u]),          32'(exp_ack(u, 1'b1)));
        check($sformatf("u%0d data", u),  32'(com_data_out[u]),     32'(e_data));
        check($sformatf("u%0d gid", u),   32'(grant_id[u]),         32'(e_gid));
    endtask

    task automatic model_edge(int u, int e);
        bit idle, dv, cv, win;
        idle = !m_active[u] || (e >= m_start[u] + we_of(u) + gap_of(u) + 1);
        dv = dbg_req[u];
        cv = cpu_req[u] && !(dbg_lock[u] && (m_last[u] == 1'b0));
        if (idle && write_ready[u] && (dv || cv)) begin
            win         = (dv && cv) ? !m_last[u] : cv;
            m_active[u] = 1;
            m_start[u]  = e;
            m_data[u]   = win ? cpu_data[u] : dbg_data[u];
            m_gid[u]    = win;
            m_last[u]   = win;
        end
    endtask

    task automatic agent(int u);
        if (dbg_req[u]) begin
            if (exp_ack(u, 1'b0)) begin
                dbg_req[u]  = ($urandom_range(0, 3) != 0);
                dbg_data[u] = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                dbg_req[u] = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            dbg_req[u]  = 1'b1;
            dbg_data[u] = 8'($urandom);
        end
        if (cpu_hold) begin
            if (!cpu_req[u] || exp_ack(u, 1'b1)) cpu_data[u] = 8'($urandom);
            cpu_req[u] = 1'b1;
        end else if (cpu_req[u]) begin
            if (exp_ack(u, 1'b1)) begin
                cpu_req[u]  = ($urandom_range(0, 3) != 0);
                cpu_data[u] = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                cpu_req[u] = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            cpu_req[u]  = 1'b1;
            cpu_data[u] = 8'($urandom);
        end
        case (lock_mode)
            1:       dbg_lock[u] = 1'b1;
            2:       dbg_lock[u] = 1'b0;
            default: if ($urandom_range(0, 9) == 0) dbg_lock[u] = !dbg_lock[u];
        endcase
        write_ready[u] = ($urandom_range(0, 7) < wr_prob);
    endtask

    // One clock: check outputs of the last edge, drive new inputs, predict the next edge.
    task automatic cycle();
        for (int u = 0; u < 2; u++) check_unit(u);
        if (agent_on) for (int u = 0; u < 2; u++) agent(u);
        for (int u = 0; u < 2; u++) model_edge(u, edge_n + 1);
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic set_in(bit dr, logic [7:0] dd, bit lk, bit cr, logic [7:0] cd, bit wr);
        for (int u = 0; u < 2; u++) begin
            dbg_req[u] = dr; dbg_data[u] = dd; dbg_lock[u] = lk;
            cpu_req[u] = cr; cpu_data[u] = cd; write_ready[u] = wr;
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must drop before the next edge.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            m_active[u] = 0;
            m_last[u]   = 1;
            check_unit(u);
        end
        set_in(0, 8'h00, 0, 0, 8'h00, 0);
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        string dump;
        int    cpu_seen;
        bit    got;
        rst = 1'b1;
        set_in(0, 8'h00, 0, 0, 8'h00, 0);
        for (int u = 0; u < 2; u++) begin
            m_active[u] = 0; m_start[u] = 0; m_last[u] = 1; m_data[u] = 8'h00; m_gid[u] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle();

        // Single debug byte.
        set_in(1, 8'h41, 0, 0, 8'h00, 1);
        cycle();
        check("single_ack", 32'(dbg_ack[0]), 32'd1);
        check("single_data", 32'(com_data_out[0]), 32'h41);
        dbg_req[0] = 0; dbg_req[1] = 0;
        repeat (8) cycle();

        // Tie round-robin with both requests held.
        set_in(1, 8'h30, 0, 1, 8'h55, 1);
        repeat (30) cycle();
        set_in(0, 8'h00, 0, 0, 8'h00, 1);
        repeat (8) cycle();

        // Locked debug burst against a continuously requesting CPU.
        dump = "0000ABCD";
        cpu_seen = 0;
        set_in(0, 8'h00, 1, 1, 8'h99, 1);
        for (int i = 0; i < 8; i++) begin
            dbg_req[0] = 1; dbg_req[1] = 1;
            dbg_data[0] = dump[i]; dbg_data[1] = dump[i];
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                cycle();
                if (exp_ack(0, 1'b1)) cpu_seen++;
                got = exp_ack(0, 1'b0);
            end
            check("lock_ack_timeout", 32'(got), 32'd1);
            dbg_req[0] = 0; dbg_req[1] = 0;
            repeat (2) cycle();
            if (exp_ack(0, 1'b1)) cpu_seen++;
        end
        repeat (8) cycle();
        check("lock_cpu_bytes", 32'(cpu_seen), 32'd0);
        dbg_lock[0] = 0; dbg_lock[1] = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            got = exp_ack(0, 1'b1);
        end
        check("unlock_cpu_ack", 32'(cpu_ack[0]), 32'd1);
        set_in(0, 8'h00, 0, 0, 8'h00, 1);
        repeat (8) cycle();

        // Backpressure, then write_ready wiggling during the byte.
        set_in(1, 8'h77, 0, 0, 8'h00, 0);
        repeat (20) cycle();
        check("bp_no_busy", 32'(busy[0]), 32'd0);
        write_ready[0] = 1; write_ready[1] = 1;
        cycle();
        check("bp_grant", 32'(dbg_ack[0]), 32'd1);
        dbg_req[0] = 0; dbg_req[1] = 0;
        for (int k = 0; k < 8; k++) begin
            write_ready[0] = 1'($urandom); write_ready[1] = write_ready[0];
            cycle();
        end

        // Request withdrawn while write_ready is low.
        set_in(1, 8'h5a, 0, 0, 8'h00, 0);
        repeat (3) cycle();
        set_in(0, 8'h5a, 0, 0, 8'h00, 1);
        repeat (5) cycle();
        check("withdraw_data", 32'(com_data_out[0]), 32'h77);

        // Reset during a strobe; first tie afterwards goes to debug.
        set_in(1, 8'h66, 0, 0, 8'h00, 1);
        cycle();
        check("pre_rst_we", 32'(com_write_enable[0]), 32'd1);
        do_reset();
        set_in(1, 8'h11, 0, 1, 8'h22, 1);
        cycle();
        check("post_rst_tie_gid", 32'(grant_id[0]), 32'd0);
        check("post_rst_tie_data", 32'(com_data_out[0]), 32'h11);
        set_in(0, 8'h00, 0, 0, 8'h00, 1);
        repeat (8) cycle();

        // Random phases with varying backpressure and lock behaviour.
        agent_on = 1;
        for (int ph = 0; ph < 6; ph++) begin
            wr_prob   = (ph % 3 == 0) ? 8 : ((ph % 3 == 1) ? 5 : 2);
            lock_mode = ph % 3;
            cpu_hold  = (ph == 4);
            repeat (500) cycle();
        end
        agent_on = 0;
        do_reset();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
